// File: rtl/axi_write_slave.sv
// AXI4 INCR write slave: one outstanding burst, beats forwarded to a registered memory write port.
// Optional feature macro: AXI_WSLV_RANGE_CHECK_EN (reject beats that fall outside MEM_BYTES).
module axi_write_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_BYTES  = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wlast,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  output logic [1:0]                axi_bresp,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned EXT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_final;
  logic                  w_last_err;
  logic                  w_range_err;

  assign w_aw_hs    = axi_awvalid & axi_awready;
  assign w_w_hs     = axi_wvalid & axi_wready;
  assign w_b_hs     = axi_bvalid & axi_bready;
  assign w_final    = (r_cnt == 8'd0);
  assign w_last_err = axi_wlast ^ w_final;

`ifdef AXI_WSLV_RANGE_CHECK_EN
  // Beat end computed one bit wider so addresses near 2^ADDR_WIDTH cannot wrap into range.
  logic [EXT_W-1:0] w_beat_end;
  assign w_beat_end  = {1'b0, r_addr} + EXT_W'(STRB_W);
  assign w_range_err = (w_beat_end > EXT_W'(MEM_BYTES));
`else
  logic [31:0] w_unused_mem_bytes;
  assign w_unused_mem_bytes = 32'(MEM_BYTES);
  assign w_range_err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; the final beat ends the burst whatever wlast says
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs)           w_state_nxt = DATA;
      DATA:    if (w_w_hs && w_final) w_state_nxt = RESP;
      RESP:    if (w_b_hs)            w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Channel ready/valid flops mirror the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_awready <= 1'b1;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
    end else begin
      axi_awready <= (w_state_nxt == IDLE);
      axi_wready  <= (w_state_nxt == DATA);
      axi_bvalid  <= (w_state_nxt == RESP);
      if (w_w_hs && w_final)
        axi_bresp <= (r_err | w_last_err | w_range_err) ? 2'b10 : 2'b00;
      else if (w_b_hs)
        axi_bresp <= 2'b00;
    end
  end

  // Burst tracking: beat address, remaining-beat counter, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= 8'd0;
      r_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_addr <= axi_awaddr;
      r_cnt  <= axi_awlen;
      r_err  <= 1'b0;
    end else if (w_w_hs) begin
      r_addr <= r_addr + ADDR_WIDTH'(STRB_W);
      r_cnt  <= r_cnt - 8'd1;
      if (w_last_err || w_range_err) r_err <= 1'b1;
    end
  end

  // Memory write port, one cycle behind the W handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= w_w_hs & ~w_range_err;
      if (w_w_hs) begin
        mem_addr  <= r_addr;
        mem_wdata <= axi_wdata;
        mem_wstrb <= axi_wstrb;
      end
    end
  end

endmodule
